bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential shift-add-3 (double-dabble) binary-to-BCD converter; downstream stage of the factorial unit.
//  Start is driven by the factorial CU Done pulse; Bin takes the factorial result (valid while OE=1).
//  Produces a registered packed-BCD result for the 7-segment display driver.
//  Iterative: one input bit per clock, so it needs no wide combinational divider.
// PARAMETERS
//  WIDTH   32  binary input width; 12! = 479001600 fits.
//  DIGITS  10  BCD digits out; must be >= ceil(WIDTH*log10(2)).
// PORTS
//  CLK    in   1          system clock, rising-edge.
//  RST    in   1          synchronous, active-high reset.
//  Start  in   1          begin a conversion; sampled only in IDLE.
//  Bin    in   WIDTH      binary operand, captured on the accepting edge.
//  Busy   out  1          1 while a conversion is in progress (CONV).
//  Valid  out  1          one-cycle pulse: BCD holds a new result.
//  BCD    out  4*DIGITS   packed BCD; digit 0 = BCD[3:0] (LSD); held between conversions.
//  Blank  out  DIGITS     leading-zero mask, 1 = blank digit (only with BCD_LZB_EN).
// BEHAVIOUR
//  - Reset: one clock, synchronous, active-high; RST wins over every other input.
//  - Values after reset: state=IDLE, Busy=0, Valid=0, BCD=0, Blank={DIGITS{1'b1}} except bit0=0, work regs=0.
//  - FSM IDLE:
//    - Start=1 loads shift reg <- Bin, BCD work reg <- 0, cnt <- 0, then goes to CONV.
//    - Start=0 stays in IDLE.
//  - FSM CONV:
//    - Each edge: every work digit >=5 gets +3, then {work,shift} shifts left by 1, and cnt increments.
//    - On the edge where cnt==WIDTH-1: output BCD <- final work value, then goes to DONE.
//  - FSM DONE: Valid=1 for this single cycle, then IDLE on the next edge.
//  - Latency: Start edge at T; Valid is high during the cycle after edge T+WIDTH (33rd cycle for 32).
//  - Back-to-back: holding Start=1 gives one conversion every WIDTH+2 cycles.
//  - Start in CONV/DONE is ignored and never queued. Bin changes after capture have no effect.
//  - The BCD output register updates only at completion, so the display never shows partial values.
//  - Digit adjust is per-nibble 4-bit; a digit is never >9 after adjust+shift.
//  - Counter width is $clog2(WIDTH).
//  - Bin=0 converts normally: the full WIDTH cycles run, and the result is all zero.
//  - Reset mid-CONV: IDLE on the next edge, BCD cleared, no Valid pulse.
//  - Busy=1 exactly in CONV; Busy and Valid are never both 1.
// CONFIGURATION
//  - BCD_LZB_EN defined:
//    - Blank is a registered output, updated with BCD.
//    - Blank[i]=1 iff digit i and all higher digits are 0, for i>=1.
//    - Blank[0] is always 0, so "0" still displays.
//  - BCD_LZB_EN undefined: Blank is tied to {DIGITS{1'b0}}; no extra logic.
// STRUCTURE
//  - Shared package fact_pkg:
//    - state enum: IDLE=2'd0, CONV=2'd1, DONE=2'd2.
//    - FACT_WIDTH=32 and FACT_DIGITS=10 constants, shared with the factorial datapath and display.
//  - One sub-module, bcd_add3: combinational 4-bit "if >=5 add 3", generated DIGITS times.
//  - FSM, counter and shift registers stay in the top.
// TESTING
//  1. RST, then Start pulse with Bin=479001600: Valid at T+33, BCD=40'h0479001600, Busy high for 32 cycles.
//  2. Bin=0: BCD=40'h0; with BCD_LZB_EN, Blank=10'b1111111110.
//  3. Bin=32'hFFFFFFFF: BCD=40'h4294967295; with BCD_LZB_EN, Blank=10'h000.
//  4. Bin=120 (5!): BCD=40'h0000000120; with BCD_LZB_EN, Blank=10'b1111111000.
//  5. Start held high, Bin toggled during CONV:
//     - results reflect only the captured values;
//     - Valid every 34 cycles;
//     - the prior BCD is held until each completion.
//  6. RST at cycle 10 of CONV: IDLE next edge, BCD=0, Valid stays 0; next Start converts correctly.

Source files
------------

// File: rtl/fact_pkg.sv
// ----------------------------------------------------------------------------
// fact_pkg
//   Constants and types shared by the factorial datapath, the binary-to-BCD
//   converter and the 7-segment display driver.
//
//   FACT_WIDTH  : binary width of the factorial result (12! fits in 32 bits).
//   FACT_DIGITS : BCD digits needed to show any FACT_WIDTH-bit value.
//   state_t     : converter FSM encoding (IDLE / CONV / DONE).
// ----------------------------------------------------------------------------
package fact_pkg;

   localparam int unsigned FACT_WIDTH  = 32;
   localparam int unsigned FACT_DIGITS = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_add3.sv
// ----------------------------------------------------------------------------
// bcd_add3
//   Combinational double-dabble digit correction: a BCD digit of 5 or more
//   gets +3 so that the following left shift carries correctly into the next
//   decade.  Inputs 0..9 only ever occur, so the 4-bit sum never wraps.
//
// Ports
//   digit    in  4  BCD digit before adjustment
//   adjusted out 4  digit, +3 when digit >= 5
// ----------------------------------------------------------------------------
module bcd_add3 (
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   always_comb begin
      adjusted = digit;
      if (digit >= 4'd5) begin
         adjusted = digit + 4'd3;
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential shift-add-3 (double-dabble) binary-to-BCD converter.  One input
//   bit is consumed per clock, so a WIDTH-bit operand takes WIDTH cycles in
//   CONV followed by a single-cycle DONE with Valid high.  The BCD output
//   register only updates on completion, so a display never sees partial
//   values.
//
// Configuration
//   BCD_LZB_EN : when defined, Blank is a registered leading-zero mask updated
//                together with BCD.  When undefined, Blank is tied low.
//
// Ports
//   CLK    in   1          rising-edge clock
//   RST    in   1          synchronous active-high reset, overrides all inputs
//   Start  in   1          start a conversion (only honoured in IDLE)
//   Bin    in   WIDTH      binary operand, captured on the accepting edge
//   Busy   out  1          high while in CONV
//   Valid  out  1          one-cycle pulse (DONE): BCD holds a new result
//   BCD    out  4*DIGITS   packed BCD result, digit 0 in BCD[3:0]
//   Blank  out  DIGITS     leading-zero mask, 1 = blank digit
// ----------------------------------------------------------------------------
module bin_to_bcd_seq
   import fact_pkg::*;
#(
   parameter int unsigned WIDTH  = FACT_WIDTH,
   parameter int unsigned DIGITS = FACT_DIGITS
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  Start,
   input  logic [WIDTH-1:0]      Bin,
   output logic                  Busy,
   output logic                  Valid,
   output logic [4*DIGITS-1:0]   BCD,
   output logic [DIGITS-1:0]     Blank
);

   localparam int unsigned    CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      shift_q;
   logic [4*DIGITS-1:0]   work_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [4*DIGITS-1:0]   bcd_q;

   logic                  last_bit;
   logic [4*DIGITS-1:0]   work_adj;
   logic [4*DIGITS-1:0]   work_shifted;
   logic [WIDTH-1:0]      shift_shifted;

   assign last_bit = (cnt_q == CNT_LAST);

   // Per-digit +3 correction ahead of the shift.
   for (genvar gi = 0; gi < int'(DIGITS); gi++) begin : g_adj
      bcd_add3 u_add3 (
         .digit    (work_q[4*gi +: 4]),
         .adjusted (work_adj[4*gi +: 4])
      );
   end

   // {work, shift} shifted left by one: the binary MSB enters the BCD LSB.
   assign work_shifted  = {work_adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
   assign shift_shifted = {shift_q[WIDTH-2:0], 1'b0};

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (Start) state_d = CONV;
         CONV:    if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      Busy  = (state_q == CONV);
      Valid = (state_q == DONE);
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge CLK) begin
      if (RST) begin
         shift_q <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (Start) begin
                  shift_q <= Bin;
                  work_q  <= '0;
                  cnt_q   <= '0;
               end
            end
            CONV: begin
               shift_q <= shift_shifted;
               work_q  <= work_shifted;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last_bit) begin
                  bcd_q <= work_shifted;
               end
            end
            default: ;
         endcase
      end
   end

   assign BCD = bcd_q;

`ifdef BCD_LZB_EN
   logic [DIGITS-1:0] blank_q, blank_d;

   // Scan from the most significant digit down; a digit is blank while every
   // digit at or above it is zero.  Digit 0 always shows so zero reads "0".
   always_comb begin
      logic seen_nz;
      seen_nz = 1'b0;
      blank_d = '0;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         seen_nz    = seen_nz | (work_shifted[4*i +: 4] != 4'd0);
         blank_d[i] = ~seen_nz;
      end
      blank_d[0] = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
      end else if (state_q == CONV && last_bit) begin
         blank_q <= blank_d;
      end
   end

   assign Blank = blank_q;
`else
   assign Blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//   Self-checking bench for bin_to_bcd_seq: a table of directed conversions,
//   then back-to-back, reset-in-CONV and Start-ignored sequences.
// ----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] bin;
   logic        busy;
   logic        valid;
   logic [39:0] bcd;
   logic [9:0]  blank;

   int n_cmp;
   int n_err;

   bin_to_bcd_seq #(
      .WIDTH  (32),
      .DIGITS (10)
   ) dut (
      .CLK   (clk),
      .RST   (rst),
      .Start (start),
      .Bin   (bin),
      .Busy  (busy),
      .Valid (valid),
      .BCD   (bcd),
      .Blank (blank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] bin;
      logic [39:0] bcd;
      logic [9:0]  blank;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [9:0] exp_blank(input logic [9:0] lzb);
`ifdef BCD_LZB_EN
      return lzb;
`else
      return 10'h000 & lzb;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for Valid, toggling Bin each cycle; counts edges and
   // any change of BCD before completion.
   task automatic wait_valid(input logic [39:0] hold, output int edges, output int hold_bad);
      edges    = 0;
      hold_bad = 0;
      while (edges < 60) begin
         if (bcd !== hold) hold_bad++;
         if (busy && valid) hold_bad++;
         tick();
         edges++;
         if (valid) break;
         bin = $urandom;
      end
   endtask

   // One full conversion from IDLE, with timing, Busy and hold checks.
   task automatic convert(input string name, input logic [31:0] b,
                          input logic [39:0] exp_bcd, input logic [9:0] lzb);
      logic [39:0] prior;
      int          edges;
      int          busy_n;
      int          hold_bad;
      prior    = bcd;
      edges    = 0;
      busy_n   = 0;
      hold_bad = 0;
      start    = 1'b1;
      bin      = b;
      tick();
      start    = 1'b0;
      bin      = ~b;
      while (edges < 40) begin
         if (busy) busy_n++;
         if (busy && valid) hold_bad++;
         if (bcd !== prior) hold_bad++;
         tick();
         edges++;
         if (valid) break;
      end
      check({name, " latency"}, 64'(edges), 64'd32);
      check({name, " busy cycles"}, 64'(busy_n), 64'd32);
      check({name, " held/exclusive"}, 64'(hold_bad), 64'd0);
      check({name, " bcd"}, 64'(bcd), 64'(exp_bcd));
      check({name, " blank"}, 64'(blank), 64'(exp_blank(lzb)));
      check({name, " busy in done"}, 64'(busy), 64'd0);
      tick();
      check({name, " valid pulse"}, 64'(valid), 64'd0);
   endtask

   initial begin
      int edges;
      int hold_bad;
      int vcount;

      n_cmp = 0;
      n_err = 0;

      vecs[0] = '{32'd479001600, 40'h0479001600, 10'b1000000000};
      vecs[1] = '{32'd0,         40'h0000000000, 10'b1111111110};
      vecs[2] = '{32'hFFFFFFFF,  40'h4294967295, 10'b0000000000};
      vecs[3] = '{32'd120,       40'h0000000120, 10'b1111111000};
      vecs[4] = '{32'd1,         40'h0000000001, 10'b1111111110};
      vecs[5] = '{32'd10,        40'h0000000010, 10'b1111111100};
      vecs[6] = '{32'd65535,     40'h0000065535, 10'b1111100000};
      vecs[7] = '{32'd1000000000,40'h1000000000, 10'b0000000000};
      vecs[8] = '{32'd99999,     40'h0000099999, 10'b1111100000};
      vecs[9] = '{32'd3628800,   40'h0003628800, 10'b1110000000};

      // Reset, with Start asserted to show RST has priority.
      rst   = 1'b1;
      start = 1'b1;
      bin   = 32'd12345;
      tick();
      tick();
      check("reset busy", 64'(busy), 64'd0);
      check("reset valid", 64'(valid), 64'd0);
      check("reset bcd", 64'(bcd), 64'd0);
      check("reset blank", 64'(blank), 64'(exp_blank(10'b1111111110)));
      start = 1'b0;
      rst   = 1'b0;
      tick();
      check("idle no start", 64'(busy), 64'd0);

      // Table-driven conversions.
      for (int i = 0; i < 10; i++) begin
         convert($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].blank);
      end

      // Back-to-back with Start held high and Bin toggled during CONV.
      start = 1'b1;
      bin   = 32'd479001600;
      tick();
      bin   = $urandom;
      wait_valid(40'h0003628800, edges, hold_bad);
      check("b2b first latency", 64'(edges), 64'd32);
      check("b2b first hold", 64'(hold_bad), 64'd0);
      check("b2b first bcd", 64'(bcd), 64'h0479001600);

      bin = 32'd120;
      tick();
      check("b2b done->idle", 64'(busy), 64'd0);
      tick();
      check("b2b recapture", 64'(busy), 64'd1);
      bin = $urandom;
      wait_valid(40'h0479001600, edges, hold_bad);
      check("b2b period 2", 64'(edges + 2), 64'd34);
      check("b2b hold 2", 64'(hold_bad), 64'd0);
      check("b2b bcd 2", 64'(bcd), 64'h0000000120);
      check("b2b blank 2", 64'(blank), 64'(exp_blank(10'b1111111000)));

      bin = 32'hFFFFFFFF;
      tick();
      tick();
      bin = $urandom;
      wait_valid(40'h0000000120, edges, hold_bad);
      check("b2b period 3", 64'(edges + 2), 64'd34);
      check("b2b hold 3", 64'(hold_bad), 64'd0);
      check("b2b bcd 3", 64'(bcd), 64'h4294967295);
      start = 1'b0;
      tick();

      // Reset at cycle 10 of CONV, Start still high.
      start = 1'b1;
      bin   = 32'hFFFFFFFF;
      tick();
      for (int i = 0; i < 10; i++) tick();
      check("pre-reset busy", 64'(busy), 64'd1);
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      check("mid reset busy", 64'(busy), 64'd0);
      check("mid reset valid", 64'(valid), 64'd0);
      check("mid reset bcd", 64'(bcd), 64'd0);
      check("mid reset blank", 64'(blank), 64'(exp_blank(10'b1111111110)));
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (valid || busy) vcount++;
      end
      check("no valid after reset", 64'(vcount), 64'd0);
      convert("after reset", 32'd120, 40'h0000000120, 10'b1111111000);

      // Start pulses during CONV are ignored: only one Valid in 40 cycles.
      start = 1'b1;
      bin   = 32'd5040;
      tick();
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         start = (i % 3 == 0);
         bin   = $urandom;
         tick();
         if (valid) vcount++;
         if (i == 31) check("ignored start bcd", 64'(bcd), 64'h0000005040);
      end
      start = 1'b0;
      check("ignored start valids", 64'(vcount), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
